// File: rtl/vcpu_bus_pkg.sv
// Shared bus definitions for the two-requester (instruction/data) bus arbiter:
// request codes, arbiter state encoding, owner encodings and requester ids.
package vcpu_bus_pkg;

  localparam logic [2:0] BR_NONE  = 3'd0;
  localparam logic [2:0] BR_READ  = 3'd1;
  localparam logic [2:0] BR_WRITE = 3'd2;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_INSTR = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;

  // 1-bit requester id used by the owner and last_grant registers
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arb_rr.sv
// Two-way round-robin selector: with both requesters active, the one that did
// not receive the last grant wins.
module bus_arb_rr
  import vcpu_bus_pkg::*;
(
  input  logic i_act_i,
  input  logic i_act_d,
  input  logic i_last_grant,
  output logic o_gnt_vld,
  output logic o_gnt_id
);

  assign o_gnt_vld = i_act_i | i_act_d;

  always_comb begin
    o_gnt_id = ID_INSTR;
    if (i_act_i && i_act_d) o_gnt_id = ~i_last_grant;
    else if (i_act_d)       o_gnt_id = ID_DATA;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Instruction/data bus arbiter with burst cap and round-robin fairness.
// Optional ownership watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import vcpu_bus_pkg::*;
#(
  parameter int BURST_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] I_A,
  input  logic [2:0]  I_BR,
  input  logic [1:0]  I_SIZ,
  input  logic [31:0] D_A,
  input  logic [2:0]  D_BR,
  input  logic [1:0]  D_SIZ,
  input  logic [31:0] D_DW,
  output logic        I_COMPL,
  output logic        D_COMPL,
  output logic        I_BERR,
  output logic        D_BERR,
  output logic [31:0] RD,
  output logic [31:0] M_A,
  output logic [2:0]  M_BR,
  output logic [1:0]  M_SIZ,
  output logic [31:0] M_DW,
  input  logic [31:0] M_DIN,
  input  logic        M_COMPL,
  output logic [1:0]  OWNER
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  arb_state_t    r_state;
  logic          r_owner;
  logic          r_last_grant;
  logic [BW-1:0] r_beat;

  logic        w_i_act, w_d_act, w_gnt_vld, w_gnt_id;
  logic        w_own_act, w_oth_act, w_continue, w_load_id, w_timeout;
  logic [31:0] w_ld_a, w_ld_dw;
  logic [2:0]  w_ld_br;
  logic [1:0]  w_ld_siz;

  assign w_i_act = (I_BR != BR_NONE);
  assign w_d_act = (D_BR != BR_NONE);

  bus_arb_rr u_rr (
    .i_act_i      (w_i_act),
    .i_act_d      (w_d_act),
    .i_last_grant (r_last_grant),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_id     (w_gnt_id)
  );

  // Requester whose A/BR/SIZ/DW gets loaded at the next grant or reload
  always_comb begin
    w_own_act  = r_owner ? w_d_act : w_i_act;
    w_oth_act  = r_owner ? w_i_act : w_d_act;
    w_continue = w_own_act && (r_beat < BMAX);
    case (r_state)
      ST_IDLE: w_load_id = w_gnt_id;
      ST_HOLD: w_load_id = w_continue ? r_owner : ~r_owner;
      default: w_load_id = r_owner;
    endcase
  end

  assign w_ld_a   = (w_load_id == ID_DATA) ? D_A   : I_A;
  assign w_ld_br  = (w_load_id == ID_DATA) ? D_BR  : I_BR;
  assign w_ld_siz = (w_load_id == ID_DATA) ? D_SIZ : I_SIZ;
  assign w_ld_dw  = (w_load_id == ID_DATA) ? D_DW  : 32'd0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_owner      <= ID_INSTR;
      r_last_grant <= ID_INSTR;
      r_beat       <= '0;
      M_A          <= '0;
      M_BR         <= BR_NONE;
      M_SIZ        <= '0;
      M_DW         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_owner <= w_load_id;
            r_beat  <= '0;
            M_A     <= w_ld_a;
            M_BR    <= w_ld_br;
            M_SIZ   <= w_ld_siz;
            M_DW    <= w_ld_dw;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (M_COMPL) begin
            M_BR         <= BR_NONE;
            r_last_grant <= r_owner;
            r_state      <= ST_HOLD;
            if (r_beat < BMAX) r_beat <= r_beat + BW'(1);
          end else if (w_timeout) begin
            M_BR         <= BR_NONE;
            r_last_grant <= r_owner;
            r_state      <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Owner keeps the bus without arbitration until the burst cap
          if (w_continue || w_oth_act) begin
            r_owner <= w_load_id;
            if (!w_continue) r_beat <= '0;
            M_A     <= w_ld_a;
            M_BR    <= w_ld_br;
            M_SIZ   <= w_ld_siz;
            M_DW    <= w_ld_dw;
            r_state <= ST_OWN;
          end else begin
            r_beat  <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_i_berr, r_d_berr;

  // Completion in the same cycle takes priority over the timeout
  assign w_timeout = (r_state == ST_OWN) && !M_COMPL && (r_wd == WD_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wd     <= '0;
      r_i_berr <= 1'b0;
      r_d_berr <= 1'b0;
    end else begin
      r_wd     <= (r_state == ST_OWN && !M_COMPL) ? r_wd + WD_W'(1) : '0;
      r_i_berr <= w_timeout && (r_owner == ID_INSTR);
      r_d_berr <= w_timeout && (r_owner == ID_DATA);
    end
  end

  assign I_BERR = r_i_berr;
  assign D_BERR = r_d_berr;
`else
  assign w_timeout = 1'b0;
  assign I_BERR    = 1'b0;
  assign D_BERR    = 1'b0;
`endif

  assign I_COMPL = (r_state == ST_OWN) && M_COMPL && (r_owner == ID_INSTR);
  assign D_COMPL = (r_state == ST_OWN) && M_COMPL && (r_owner == ID_DATA);
  assign RD      = M_DIN;
  assign OWNER   = (r_state == ST_IDLE) ? OWN_NONE :
                   (r_owner == ID_DATA) ? OWN_DATA : OWN_INSTR;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be: BURST_MAX, 4, max consecutive beats one owner holds the bus; TIMEOUT_CYCLES, 255, watchdog limit in cycles.
REQ-002 Port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Port RESET  in  1  asynchronous, active-high reset.
REQ-004 Ports I_A/D_A  in  32  requester address; I_BR/D_BR  in  3  bus request code (BR_NONE/BR_READ/BR_WRITE); I_SIZ/D_SIZ  in  2  transfer size; D_DW  in  32  data-cache write data (the instruction side never writes).
REQ-005 Ports I_COMPL/D_COMPL  out  1  per-requester completion; I_BERR/D_BERR  out  1  per-requester bus error; RD  out  32  read data to both requesters.
REQ-006 Ports M_A  out  32, M_BR  out  3, M_SIZ  out  2, M_DW  out  32  registered memory-side request; M_DIN  in  32  memory read data; M_COMPL  in  1  memory completion pulse.
REQ-007 Port OWNER  out  2  current grant: 00 none, 01 instruction, 10 data.

Function
REQ-008 The FSM SHALL have states IDLE, OWN and HOLD, plus a 1-bit owner register and a 1-bit last_grant register.
REQ-009 IDLE: a requester is active when its BR != BR_NONE; with one active, grant it; with both active, grant the one != last_grant.
REQ-010 On grant, the block SHALL register the owner's A/BR/SIZ/DW into M_* at the same edge and enter OWN; M_BR is valid one cycle after the request is sampled.
REQ-011 OWN: M_* SHALL hold constant until M_COMPL=1, regardless of owner input changes (owner dropping BR is ignored).
REQ-012 When M_COMPL=1, the owner's COMPL SHALL be driven combinationally high in the same cycle and RD SHALL equal M_DIN; the non-owner's COMPL SHALL stay 0.
REQ-013 On the M_COMPL edge: M_BR<=BR_NONE, beat_cnt increments (saturating at BURST_MAX), last_grant<=owner, state<=HOLD.
REQ-014 HOLD lasts one cycle: if the owner is active and beat_cnt<BURST_MAX, reload M_* from the owner and go to OWN with no arbitration; else if the other requester is active, grant it (beat_cnt<=0) and go to OWN; else go to IDLE and set beat_cnt<=0.
REQ-015 beat_cnt SHALL be ceil(log2(BURST_MAX+1)) bits wide and SHALL reset to 0 on every ownership change.
REQ-016 M_COMPL seen in IDLE or HOLD SHALL be ignored and SHALL NOT produce COMPL on either side.
REQ-017 OWNER SHALL reflect the owner in OWN and HOLD, and 00 in IDLE.
REQ-018 M_DW SHALL be 0 whenever the instruction requester owns the bus.

Reset
REQ-019 While RESET=1: state=IDLE, M_A=0, M_BR=BR_NONE, M_SIZ=0, M_DW=0, beat_cnt=0, watchdog=0, last_grant=instruction (so data wins the first tie), OWNER=00, both COMPL=0, both BERR=0.
REQ-020 Reset asserted mid-transaction SHALL abandon it immediately; no COMPL SHALL be generated for it.

Configuration
REQ-021 With BUS_ARBITER_TIMEOUT_EN defined: a watchdog counts cycles in OWN and clears on each entry to OWN.
REQ-022 With BUS_ARBITER_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES without M_COMPL, the owner's BERR pulses for one cycle, M_BR<=BR_NONE, last_grant<=owner and state<=IDLE.
REQ-023 With BUS_ARBITER_TIMEOUT_EN defined: if M_COMPL and timeout coincide, completion wins.
REQ-024 Without BUS_ARBITER_TIMEOUT_EN: BERR outputs SHALL be tied 0, no watchdog logic SHALL exist, and OWN waits indefinitely.

Structure
REQ-025 Shared package vcpu_bus_pkg SHALL hold the BR_* codes, the arbiter state enum and the OWNER encodings.
REQ-026 Two-way round-robin selection SHALL live in sub-module bus_arb_rr (inputs: two actives, last_grant; outputs: grant valid, grant id).

Verification
REQ-027 Single read: I_BR=BR_READ, I_A=0x00001000 at cycle 0 -> M_BR=BR_READ, M_A=0x00001000 at cycle 1; M_COMPL with M_DIN=0xDEADBEEF -> I_COMPL=1 and RD=0xDEADBEEF in the same cycle, D_COMPL=0.
REQ-028 Tie after reset: both request in the same cycle -> data granted (OWNER=10); after completion, instruction granted from HOLD.
REQ-029 Burst cap: instruction re-requests in every HOLD for 6 beats with data idle -> the first 4 beats complete without IDLE; beat 5 is granted via IDLE with beat_cnt=0.
REQ-030 Preemption at cap: instruction bursting with data waiting -> after beat 4, data owns; D_DW=0x12345678 appears on M_DW.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=8): data write, no M_COMPL -> D_BERR pulses exactly once at cycle 9 and M_BR=BR_NONE; with the macro off -> still OWN at cycle 100.
REQ-032 RESET asserted during OWN -> M_BR=BR_NONE immediately; a later M_COMPL yields no COMPL.
